// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int count_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int          COUNT_W = count_w(DEFAULT_WIDTH);
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: synchronous clear/enable, saturates at WIDTH, flags the last iteration.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = count_w(WIDTH)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next-count selection; holding at CNT_SAT keeps the counter from wrapping
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = CNT_ZERO;
    end else if (enable && (count_q != CNT_SAT)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == CNT_LAST);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit with a
// fixed WIDTH+1 cycle latency and a registered result/exception/ready.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int              W2      = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [W2-1:0]    ZERO_2W = {W2{1'b0}};
  localparam logic [W2-1:0]    ONE_2W  = {{(W2-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + ONE_W) : x;
  endfunction

  state_e           state_q, state_d;
  logic [W2-1:0]    acc_q, acc_d;        // MULT: product; DIV: {remainder, dividend/quotient}
  logic [W2-1:0]    mcand_q, mcand_d;    // MULT: shifted multiplicand; DIV: divisor in low half
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic             is_div_q, is_div_d;
  logic             div_zero_q, div_zero_d;
  logic             div_ovf_q, div_ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic             start_s;
  logic             cnt_clear_s;
  logic             cnt_en_s;
  logic             cnt_last_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   diff_s;
  logic [W2-1:0]    product_s;
  logic [WIDTH-1:0] quot_s;

  assign start_s     = ctrl_MULT | ctrl_DIV;
  assign rem_shift_s = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign diff_s      = rem_shift_s - {1'b0, mcand_q[WIDTH-1:0]};
  assign product_s   = neg_q ? (~acc_q + ONE_2W) : acc_q;
  assign quot_s      = neg_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];

  multdiv_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear_s),
    .enable   (cnt_en_s),
    .terminal (cnt_last_s)
  );

  // next-state and datapath; a start in any state aborts and restarts
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    is_div_d    = is_div_q;
    div_zero_d  = div_zero_q;
    div_ovf_d   = div_ovf_q;
    result_d    = result_q;
    exc_d       = exc_q;
    rdy_d       = 1'b0;
    cnt_clear_s = 1'b0;
    cnt_en_s    = 1'b0;
    if (start_s) begin
      cnt_clear_s = 1'b1;
      neg_d       = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      is_div_d    = ~ctrl_MULT;
      div_zero_d  = (data_operandB == ZERO_W);
      div_ovf_d   = (data_operandA == MIN_W) && (data_operandB == ONES_W);
      if (ctrl_MULT) begin
        state_d  = MULT;
        acc_d    = ZERO_2W;
        mcand_d  = {ZERO_W, magnitude(data_operandA)};
        mplier_d = magnitude(data_operandB);
      end else begin
        state_d  = DIV;
        acc_d    = {ZERO_W, magnitude(data_operandA)};
        mcand_d  = {ZERO_W, magnitude(data_operandB)};
        mplier_d = ZERO_W;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        MULT: begin
          cnt_en_s = 1'b1;
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1'b1;
          mplier_d = mplier_q >> 1'b1;
          state_d  = cnt_last_s ? DONE : MULT;
        end
        DIV: begin
          cnt_en_s = 1'b1;
          if (!diff_s[WIDTH]) begin
            acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          state_d = cnt_last_s ? DONE : DIV;
        end
        DONE: begin
          rdy_d   = 1'b1;
          state_d = IDLE;
          if (!is_div_q) begin
            result_d = product_s[WIDTH-1:0];
            exc_d    = (product_s[W2-1:WIDTH] != {WIDTH{product_s[WIDTH-1]}});
          end else if (div_zero_q) begin
            result_d = ZERO_W;
            exc_d    = 1'b1;
          end else if (div_ovf_q) begin
            result_d = MIN_W;
            exc_d    = 1'b1;
          end else begin
            result_d = quot_s;
            exc_d    = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= ZERO_2W;
      mcand_q    <= ZERO_2W;
      mplier_q   <= ZERO_W;
      neg_q      <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= ZERO_W;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      neg_q      <= neg_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
      rdy_q      <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expectations queued at each start edge,
// popped and compared (value, exception, latency) on every ready pulse.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  localparam int LAT = 33;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] res;
  logic        exc;
  logic        rdy;

  typedef struct {
    logic [31:0] result;
    logic        exc;
    int          start_cyc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic is_mult, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint p;
    e.start_cyc = 0;
    e.tag = "";
    if (is_mult) begin
      p = longint'($signed(x)) * longint'($signed(y));
      e.result = p[31:0];
      e.exc = (p != longint'($signed(p[31:0])));
    end else if (y == 32'd0) begin
      e.result = 32'd0;
      e.exc = 1'b1;
    end else if (x == INT_MIN && y == 32'hFFFF_FFFF) begin
      e.result = INT_MIN;
      e.exc = 1'b1;
    end else begin
      e.result = $signed(x) / $signed(y);
      e.exc = 1'b0;
    end
    return e;
  endfunction

  // scoreboard: every ready pulse must match the single in-flight expectation
  always @(negedge clock) begin
    if (rdy !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rdy", {63'd0, rdy}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq({mon_e.tag, "_result"}, {32'd0, res}, {32'd0, mon_e.result});
        check_eq({mon_e.tag, "_exc"}, {63'd0, exc}, {63'd0, mon_e.exc});
        check_eq({mon_e.tag, "_latency"}, 64'(cyc - mon_e.start_cyc), 64'(LAT));
      end
    end
  end

  // call #1 after a rising edge; the pulse is sampled at the next edge
  task automatic start_op(input string tag, input logic is_mult, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(is_mult, x, y);
    e.tag = tag;
    ctrl_MULT = is_mult;
    ctrl_DIV  = ~is_mult;
    op_a = x;
    op_b = y;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    op_a = $urandom();
    op_b = $urandom();
    e.start_cyc = cyc;
    exp_q.delete();
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_rdy(input int budget);
    int n = 0;
    while (rdy !== 1'b1 && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("rdy_seen", {63'd0, rdy}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    op_a = 32'd0;
    op_b = 32'd0;
    wait_cycles(3);
    check_eq("reset_result", {32'd0, res}, 64'd0);
    check_eq("reset_exc", {63'd0, exc}, 64'd0);
    check_eq("reset_rdy", {63'd0, rdy}, 64'd0);
    reset = 1'b0;
    wait_cycles(2);

    start_op("mul_7x-6", 1'b1, 32'd7, 32'hFFFF_FFFA);
    wait_drain(45);
    start_op("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
    wait_drain(45);
    start_op("div_-100/7", 1'b0, 32'hFFFF_FF9C, 32'd7);
    wait_drain(45);
    start_op("div_by_zero", 1'b0, 32'd5, 32'd0);
    wait_drain(45);
    start_op("div_min/-1", 1'b0, INT_MIN, 32'hFFFF_FFFF);
    wait_drain(45);

    // abort: the 3x4 result must never appear
    start_op("mul_3x4_aborted", 1'b1, 32'd3, 32'd4);
    wait_cycles(9);
    start_op("div_100/5", 1'b0, 32'd100, 32'd5);
    wait_drain(45);
    wait_cycles(5);

    // start accepted in the ready-pulse cycle
    start_op("mul_b2b_first", 1'b1, 32'hFFFF_8000, 32'd12345);
    wait_rdy(45);
    start_op("div_b2b_second", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFD);
    wait_drain(45);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom();
      rb = $urandom() >> $urandom_range(0, 31);
      if (i[0]) rb = ~rb + 32'd1;
      start_op($sformatf("rand_%0d", i), i[1], ra, rb);
      wait_drain(45);
    end

    start_op("pre_reset", 1'b1, 32'd5, 32'd5);
    wait_drain(45);

    // reset mid-operation, with a start in the same cycle that must be ignored
    start_op("mul_reset", 1'b1, 32'd123, 32'd456);
    wait_cycles(14);
    exp_q.delete();
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    op_a = 32'd9;
    op_b = 32'd9;
    wait_cycles(1);
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    check_eq("midreset_result", {32'd0, res}, 64'd0);
    check_eq("midreset_exc", {63'd0, exc}, 64'd0);
    check_eq("midreset_rdy", {63'd0, rdy}, 64'd0);
    wait_cycles(40);

    start_op("mul_after_reset", 1'b1, 32'd7, 32'hFFFF_FFFA);
    wait_drain(45);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
